// File: rtl/simpu_pkg.sv
// Shared definitions for the simple CPU pipeline.
// Contents: address/data widths, opcode field position, halt opcode and
// the fetch-stage state encoding.
`timescale 1ns/1ps
package simpu_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 32;

  // Opcode field of an instruction word
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 28;

  localparam logic [3:0]  HALT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StHalt  = 2'd1,
    StFault = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of {pc, instr} between fetch and decode.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   push, wdata    enqueue request and data (dropped if full without a pop)
//   pop            dequeue request (ignored when empty)
//   flush          empties the FIFO; overrides push/pop
//   rdata          head entry (registered)
//   full, empty    occupancy flags
`timescale 1ns/1ps
module fetch_fifo
  import simpu_pkg::*;
#(
  parameter int unsigned WIDTH = ADDR_W + DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic [1:0]       count_q, count_d;
  logic             pop_eff, push_eff, wslot;

  assign pop_eff  = pop && (count_q != 2'd0);
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_eff = push && ((count_q != 2'd2) || pop_eff);
  // Write slot after the optional shift of entry 1 into the head
  assign wslot    = (count_q == 2'd2) || ((count_q == 2'd1) && !pop_eff);

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop_eff) begin
        mem_d[0] = mem_q[1];
      end
      if (push_eff) begin
        mem_d[wslot] = wdata;
      end
      count_d = count_q + {1'b0, push_eff} - {1'b0, pop_eff};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q   <= '{default: '0};
      count_q <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[0];
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, addresses instruction memory, and
// queues {pc, instr} pairs for decode in a 2-entry FIFO (valid/ready).
// Handles branch redirect (flush + PC reload) and halt on HALT_OPCODE.
// Optional: define INST_FETCH_BOUNDS_EN to fault on fetches at pc >= IMEM_DEPTH.
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   imem_addr / imem_data         word address out, instruction in (same cycle)
//   redirect_valid / redirect_pc  taken branch: flush and reload PC
//   out_valid / out_ready         decode handshake
//   out_instr / out_pc            head instruction and its PC
//   halted                        fetch stopped on a halt word
//   fault                         sticky bounds fault (0 without INST_FETCH_BOUNDS_EN)
`timescale 1ns/1ps
module inst_fetch
  import simpu_pkg::*;
#(
  parameter int unsigned       ADDR_W      = simpu_pkg::ADDR_W,
  parameter int unsigned       DATA_W      = simpu_pkg::DATA_W,
  parameter int unsigned       IMEM_DEPTH  = 256,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [3:0]        HALT_OPCODE = simpu_pkg::HALT_OPCODE
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic              fault
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  fetch_state_e      state_q, state_d;
  logic              push, pop, flush, full, empty;
  logic              can_fetch, is_halt, out_of_bounds;

  assign pop       = out_valid && out_ready;
  assign can_fetch = !full || pop;
  assign is_halt   = (imem_data[OPC_MSB:OPC_LSB] == HALT_OPCODE);

`ifdef INST_FETCH_BOUNDS_EN
  assign out_of_bounds = (32'(pc_q) >= IMEM_DEPTH);
  assign fault         = (state_q == StFault);
`else
  logic unused_depth;
  assign unused_depth  = ^IMEM_DEPTH;
  assign out_of_bounds = 1'b0;
  assign fault         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid && (state_q != StFault)) begin
      // Redirect wins over fetch; a same-cycle dequeue still completes
      flush   = 1'b1;
      pc_d    = redirect_pc;
      state_d = StFetch;
    end else if ((state_q == StFetch) && can_fetch) begin
      if (out_of_bounds) begin
        state_d = StFault;
      end else begin
        push = 1'b1;
        pc_d = pc_q + ADDR_W'(1);
        if (is_halt) begin
          state_d = StHalt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      state_q <= StFetch;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fetch_fifo #(
    .WIDTH(ADDR_W + DATA_W)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .wdata({pc_q, imem_data}),
    .rdata({out_pc, out_instr}),
    .full (full),
    .empty(empty)
  );

  assign imem_addr = pc_q;
  assign out_valid = !empty;
  assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch. The reference model describes the
// instruction stream: from any start PC, consecutive words up to and including
// the first halt word (or up to the bounds limit when bounds checking is built in).
// A redirect discards whatever has not yet been accepted by decode.
`timescale 1ns/1ps
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic        halted;
  logic        fault;

  inst_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .halted        (halted),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [65536];
  assign imem_data = imem[imem_addr];

  int          total = 0;
  int          bad = 0;
  logic [47:0] sb [$];
  bit          rnd = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected stream from a start PC
  task automatic walk(input logic [15:0] start);
    logic [15:0] p;
    p = start;
    for (int n = 0; n < 400; n++) begin
`ifdef INST_FETCH_BOUNDS_EN
      if (p >= 16'd256) break;
`endif
      sb.push_back({p, imem[p]});
      if (imem[p][31:28] == 4'hF) break;
      p = p + 16'd1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Assert redirect for one cycle; 'take' says whether the model expects it honoured
  task automatic redirect(input logic [15:0] t, input bit take);
    @(negedge clk);
    #1;
    redirect_pc    = t;
    redirect_valid = 1'b1;
    if (take) begin
      sb.delete();
      walk(t);
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      step();
      n++;
    end
    repeat (3) step();
    check(nm, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compares every transfer against the scoreboard head
  initial begin
    logic        stall_prev;
    logic [47:0] held;
    logic [47:0] exp;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (stall_prev && out_valid) check("hold_stable", {out_pc, out_instr}, held);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got pc=%0h instr=%0h expected none", out_pc, out_instr);
          end else begin
            exp = sb.pop_front();
            check("stream", {out_pc, out_instr}, exp);
          end
        end
        stall_prev = out_valid && !out_ready;
        held       = {out_pc, out_instr};
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] w;
    int          t, len;
    for (int i = 0; i < 65536; i++) begin
      w        = $urandom;
      w[31:28] = 4'($urandom_range(0, 14));
      imem[i]  = w;
    end
    imem[0] = 32'h6040_0000;
    imem[1] = 32'h6040_0014;
    imem[2] = 32'h6080_0000;
    imem[3] = 32'hF000_0000;
    imem[16'h48] = 32'hF000_0048;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_instr", 64'(out_instr), 64'd0);
    check("rst_pc", 64'(out_pc), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);

    // Back-to-back stream after reset release, ending on the halt word at 3
    @(negedge clk);
    reset = 1'b1;
    walk(16'd0);
    step();
    check("t1_valid0", 64'(out_valid), 64'd1);
    check("t1_pc0", 64'(out_pc), 64'd0);
    check("t1_instr0", 64'(out_instr), 64'h6040_0000);
    step();
    check("t1_pc1", 64'(out_pc), 64'd1);
    check("t1_instr1", 64'(out_instr), 64'h6040_0014);
    step();
    check("t1_pc2", 64'(out_pc), 64'd2);
    check("t1_instr2", 64'(out_instr), 64'h6080_0000);
    step();
    check("t4_pc3", 64'(out_pc), 64'd3);
    check("t4_halted", 64'(halted), 64'd1);
    check("t4_addr", 64'(imem_addr), 64'd4);
    step();
    check("t4_addr_hold", 64'(imem_addr), 64'd4);
    check("t4_halted_hold", 64'(halted), 64'd1);

    // Backpressure: buffer fills, pc holds
    out_ready = 1'b0;
    redirect(16'd0, 1'b1);
    check("t4_unhalt", 64'(halted), 64'd0);
    check("t2_flush_valid", 64'(out_valid), 64'd0);
    repeat (5) step();
    check("t2_addr_hold", 64'(imem_addr), 64'd2);
    check("t2_pc_hold", 64'(out_pc), 64'd0);
    check("t2_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    drain("t2_drain");
    check("t2_halted", 64'(halted), 64'd1);

    // Redirect while full
    out_ready = 1'b0;
    redirect(16'd0, 1'b1);
    repeat (2) step();
    check("t3_full_addr", 64'(imem_addr), 64'd2);
    redirect(16'h0040, 1'b1);
    check("t3_valid_low", 64'(out_valid), 64'd0);
    check("t3_addr", 64'(imem_addr), 64'h40);
    step();
    check("t3_valid", 64'(out_valid), 64'd1);
    check("t3_pc", 64'(out_pc), 64'h40);
    out_ready = 1'b1;
    drain("t3_drain");

    // Random redirects and backpressure
    rnd = 1'b1;
    for (int s = 0; s < 14; s++) begin
      t   = $urandom_range(8, 200);
      len = $urandom_range(0, 15);
      imem[t + len] = {4'hF, 28'($urandom)};
      redirect(16'(t), 1'b1);
      repeat ($urandom_range(0, 25)) step();
    end
    drain("rnd_drain");
    check("rnd_halted", 64'(halted), 64'd1);
    rnd = 1'b0;
    out_ready = 1'b1;

    // Asynchronous reset mid-stream
    redirect(16'h0040, 1'b1);
    step();
    check("t5_pre_valid", 64'(out_valid), 64'd1);
    #1;
    reset = 1'b0;
    sb.delete();
    #1;
    check("t5_valid", 64'(out_valid), 64'd0);
    check("t5_addr", 64'(imem_addr), 64'd0);
    check("t5_pc", 64'(out_pc), 64'd0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    walk(16'd0);
    drain("t5_drain");

    // Bounds behaviour at the top of the implemented memory
    imem[16'h00FF] = 32'h1234_5678;
    imem[16'h0100] = 32'h2345_6789;
    imem[16'h0101] = 32'hF000_0101;
    redirect(16'h00FF, 1'b1);
    drain("t6_drain");
`ifdef INST_FETCH_BOUNDS_EN
    check("t6_fault", 64'(fault), 64'd1);
    check("t6_addr", 64'(imem_addr), 64'h100);
    check("t6_halted", 64'(halted), 64'd0);
    redirect(16'd0, 1'b0);
    repeat (3) step();
    check("t6_ign_addr", 64'(imem_addr), 64'h100);
    check("t6_ign_fault", 64'(fault), 64'd1);
    check("t6_ign_valid", 64'(out_valid), 64'd0);
`else
    check("t6_fault", 64'(fault), 64'd0);
    check("t6_halted", 64'(halted), 64'd1);
    check("t6_addr", 64'(imem_addr), 64'h102);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
